// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// Owner IDs, FSM state encodings and default widths live here.
package regfile_arb_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Bus bundle between the two write requesters, the register file and the arbiter.
// Handshake: a req is sampled only while the arbiter is idle; the matching ack pulses once when the write commits.
interface regfile_arbiter_if #(
  parameter int DATA_W = regfile_arb_pkg::DATA_W_DEF,
  parameter int ADDR_W = regfile_arb_pkg::ADDR_W_DEF
) ();

  logic              core_req;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_data;
  logic              core_ack;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_ack;
  logic              dbg_lock;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              busy;
  logic [1:0]        st;

  modport master (
    output core_req, core_addr, core_data, dbg_req, dbg_addr, dbg_data, dbg_lock,
    input  core_ack, dbg_ack, rf_we, rf_addr, rf_data, busy, st
  );

  modport slave (
    input  core_req, core_addr, core_data, dbg_req, dbg_addr, dbg_data, dbg_lock,
    output core_ack, dbg_ack, rf_we, rf_addr, rf_data, busy, st
  );

endinterface

// File: rtl/regfile_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time is granted.
module rr_pick2
  import regfile_arb_pkg::*;
(
  input  logic   req_core,
  input  logic   req_dbg,
  input  owner_t last_owner,
  output owner_t grant
);

  always_comb begin
    grant = OWN_CORE;
    if (req_core && req_dbg)
      grant = (last_owner == OWN_CORE) ? OWN_DBG : OWN_CORE;
    else if (req_dbg)
      grant = OWN_DBG;
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates core and debug writes into one register-file write port (IDLE -> WRITE -> ACK).
// Optional RFARB_LOCK_EN: dbg_lock blocks new core grants while it is high.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic              clk,
  input logic              rst,
  regfile_arbiter_if.slave bus
);

  state_t            state, state_d;
  owner_t            owner, owner_d;
  owner_t            last_owner, last_owner_d;
  owner_t            grant;
  logic [ADDR_W-1:0] lat_addr, lat_addr_d;
  logic [DATA_W-1:0] lat_data, lat_data_d;
  logic              core_elig;
  logic              dbg_elig;
  logic              core_ack_c;
  logic              dbg_ack_c;

`ifdef RFARB_LOCK_EN
  assign core_elig = bus.core_req & ~bus.dbg_lock;
`else
  logic unused_lock;
  assign unused_lock = bus.dbg_lock;
  assign core_elig   = bus.core_req;
`endif
  assign dbg_elig = bus.dbg_req;

  rr_pick2 u_pick (
    .req_core   (core_elig),
    .req_dbg    (dbg_elig),
    .last_owner (last_owner),
    .grant      (grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= OWN_CORE;
      last_owner <= OWN_DBG;
      lat_addr   <= '0;
      lat_data   <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_owner <= last_owner_d;
      lat_addr   <= lat_addr_d;
      lat_data   <= lat_data_d;
    end
  end

  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_owner_d = last_owner;
    lat_addr_d   = lat_addr;
    lat_data_d   = lat_data;
    core_ack_c   = 1'b0;
    dbg_ack_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (core_elig || dbg_elig) begin
          state_d    = S_WRITE;
          owner_d    = grant;
          lat_addr_d = (grant == OWN_DBG) ? bus.dbg_addr : bus.core_addr;
          lat_data_d = (grant == OWN_DBG) ? bus.dbg_data : bus.core_data;
        end
      end
      S_WRITE: state_d = S_ACK;
      S_ACK: begin
        state_d      = S_IDLE;
        last_owner_d = owner;
        core_ack_c   = (owner == OWN_CORE);
        dbg_ack_c    = (owner == OWN_DBG);
      end
      // Unused encoding 3 falls back to idle.
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rf_we    = (state == S_WRITE);
  assign bus.rf_addr  = lat_addr;
  assign bus.rf_data  = lat_data;
  assign bus.core_ack = core_ack_c;
  assign bus.dbg_ack  = dbg_ack_c;
  assign bus.busy     = (state != S_IDLE);
  assign bus.st       = state;

endmodule
